// File: rtl/k_nns_dist_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : k_nns_dist_pipe
//  Description : Streaming squared-Euclidean-distance front-end for the
//                sequential k-NN sorter. Latches one query point, accepts N
//                database points over valid/ready and emits
//                {point, distance, last} through a 3-stage pipeline that
//                stalls as a whole on downstream backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module k_nns_dist_pipe #(
    parameter int W  = 32,
    parameter int N  = 64,
    parameter int CW = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            q_load,
    input  logic [2*W-1:0]  q_point,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*W-1:0]  in_point,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  out_point,
    output logic [2*W:0]    out_dist,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    // FSM encoding
    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_drain = 2'd2;

    // Count value held before the accept of the final point of a query
    localparam logic [CW-1:0] c_last_cnt = CW'(N - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [2*W-1:0]      r_query;
    logic [CW-1:0]       r_count;

    // Stage 1: signed coordinate differences
    logic                r_v1;
    logic                r_l1;
    logic [2*W-1:0]      r_p1;
    logic signed [W:0]   r_dx;
    logic signed [W:0]   r_dy;

    // Stage 2: per-axis squares
    logic                r_v2;
    logic                r_l2;
    logic [2*W-1:0]      r_p2;
    logic [2*W-1:0]      r_sqx;
    logic [2*W-1:0]      r_sqy;

    // Stage 3: final distance, drives the outputs
    logic                r_v3;
    logic                r_l3;
    logic [2*W-1:0]      r_p3;
    logic [2*W:0]        r_dist;

    logic                w_en;
    logic                w_accept;
    logic                w_final_accept;
    logic                w_handoff_last;
    logic signed [W:0]   w_dx;
    logic signed [W:0]   w_dy;
    logic [2*W-1:0]      w_ext_x;
    logic [2*W-1:0]      w_ext_y;
    logic [2*W-1:0]      w_sqx;
    logic [2*W-1:0]      w_sqy;

    // Single enable: every stage moves only when the output slot can drain
    assign w_en           = ~r_v3 | out_ready;
    assign in_ready       = (r_state == c_run) & w_en;
    assign w_accept       = in_valid & in_ready;
    assign w_final_accept = w_accept & (r_count == c_last_cnt);
    assign w_handoff_last = r_v3 & r_l3 & out_ready;

    // Sign-extend both operands to W+1 bits so the difference cannot overflow
    assign w_dx = $signed({in_point[2*W-1], in_point[2*W-1:W]})
                - $signed({r_query[2*W-1],  r_query[2*W-1:W]});
    assign w_dy = $signed({in_point[W-1], in_point[W-1:0]})
                - $signed({r_query[W-1],  r_query[W-1:0]});

    // A 2W-bit product of the sign-extended difference is the exact square,
    // because |d| <= 2^W-1 keeps d*d below 2^(2W)
    assign w_ext_x = {{(W-1){r_dx[W]}}, r_dx};
    assign w_ext_y = {{(W-1){r_dy[W]}}, r_dy};
    assign w_sqx   = w_ext_x * w_ext_x;
    assign w_sqy   = w_ext_y * w_ext_y;

    assign out_valid = r_v3;
    assign out_point = r_p3;
    assign out_dist  = r_dist;
    assign out_last  = r_v3 & r_l3;
    assign busy      = (r_state == c_run) | (r_state == c_drain);
    assign done      = (r_state == c_drain) & w_handoff_last;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: load -> stream N points -> wait for the last handoff
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (q_load) begin
                    w_state_nxt = c_run;
                end
            end
            c_run: begin
                if (w_final_accept) begin
                    w_state_nxt = c_drain;
                end
            end
            c_drain: begin
                if (w_handoff_last) begin
                    w_state_nxt = c_idle;
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    // Query latch and accepted-point counter; q_load is ignored outside IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_query <= '0;
            r_count <= '0;
        end else if ((r_state == c_idle) && q_load) begin
            r_query <= q_point;
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + c_cnt_one;
        end
    end

    // Stage 1: capture the point and its differences; empty slots enter as bubbles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1 <= 1'b0;
            r_l1 <= 1'b0;
            r_p1 <= '0;
            r_dx <= '0;
            r_dy <= '0;
        end else if (w_en) begin
            r_v1 <= w_accept;
            r_l1 <= w_final_accept;
            r_p1 <= in_point;
            r_dx <= w_dx;
            r_dy <= w_dy;
        end
    end

    // Stage 2: square each axis difference
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v2  <= 1'b0;
            r_l2  <= 1'b0;
            r_p2  <= '0;
            r_sqx <= '0;
            r_sqy <= '0;
        end else if (w_en) begin
            r_v2  <= r_v1;
            r_l2  <= r_l1;
            r_p2  <= r_p1;
            r_sqx <= w_sqx;
            r_sqy <= w_sqy;
        end
    end

    // Stage 3: sum into a 2W+1-bit result; holds stable while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v3   <= 1'b0;
            r_l3   <= 1'b0;
            r_p3   <= '0;
            r_dist <= '0;
        end else if (w_en) begin
            r_v3   <= r_v2;
            r_l3   <= r_l2;
            r_p3   <= r_p2;
            r_dist <= {1'b0, r_sqx} + {1'b0, r_sqy};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_k_nns_dist_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_k_nns_dist_pipe
//  Description : Scoreboard bench for k_nns_dist_pipe. Accepted points are
//                turned into expected results by an arithmetic reference
//                model; a monitor pops and compares each delivered result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_k_nns_dist_pipe;

    localparam int W  = 32;
    localparam int N  = 64;
    localparam int CW = 7;

    logic            clk;
    logic            rst;
    logic            q_load;
    logic [2*W-1:0]  q_point;
    logic            in_valid;
    logic            in_ready;
    logic [2*W-1:0]  in_point;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out_point;
    logic [2*W:0]    out_dist;
    logic            out_last;
    logic            busy;
    logic            done;

    k_nns_dist_pipe #(.W(W), .N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .q_load    (q_load),
        .q_point   (q_point),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_point  (in_point),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_point (out_point),
        .out_dist  (out_dist),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [63:0] p;
        logic [64:0] d;
        bit          last;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          m_idle = 1;
    int          m_cnt = 0;
    logic [63:0] m_q = '0;
    bit          handoff_now = 0;
    bit          lat_mode = 0;
    bit          rnd_ready = 0;
    bit          prev_stall = 0;
    logic [63:0] held_p;
    logic [64:0] held_d;
    bit          held_l;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pt(input int x, input int y);
        return {x[31:0], y[31:0]};
    endfunction

    // Exact squared distance in wide signed arithmetic
    function automatic logic [64:0] ref_dist(input logic [63:0] p, input logic [63:0] q);
        logic signed [129:0] dx, dy, s;
        dx = $signed(p[63:32]);
        dx = dx - $signed(q[63:32]);
        dy = $signed(p[31:0]);
        dy = dy - $signed(q[31:0]);
        s  = dx * dx + dy * dy;
        return s[64:0];
    endfunction

    function automatic logic [31:0] rnd_coord();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 32'h8000_0000;
        if (sel == 1) return 32'h7FFF_FFFF;
        return $urandom;
    endfunction

    function automatic logic [63:0] rnd_point();
        return {rnd_coord(), rnd_coord()};
    endfunction

    // Reference tracking: query loads, accepts and protocol rules on the input side
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            chk(busy == !m_idle, "busy", busy, !m_idle);
            if (m_idle || m_cnt == N)
                chk(in_ready == 1'b0, "in_ready_closed", in_ready, 0);
            if (out_valid && !out_ready)
                chk(in_ready == 1'b0, "in_ready_stall", in_ready, 0);
            if (q_load && m_idle) begin
                m_q = q_point;
                m_cnt = 0;
                m_idle = 0;
            end
            if (in_valid && in_ready) begin
                exp_t e;
                m_cnt++;
                e.p = in_point;
                e.d = ref_dist(in_point, m_q);
                e.last = (m_cnt == N);
                e.acc_cyc = cyc;
                e.chk_lat = lat_mode;
                sb.push_back(e);
            end
            if (handoff_now) begin
                m_idle = 1;
                handoff_now = 0;
            end
        end
    end

    // Monitor: compare every delivered result against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            bit exp_done;
            exp_done = 0;
            if (prev_stall) begin
                chk(out_valid == 1'b1, "stall_valid_hold", out_valid, 1);
                chk(out_point == held_p && out_dist == held_d && out_last == held_l,
                    "stall_data_hold", {out_last, out_dist}, {held_l, held_d});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk(0, "unexpected_output", out_dist, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk(out_point == e.p, "out_point", out_point, e.p);
                    chk(out_dist == e.d, "out_dist", out_dist, e.d);
                    chk(out_last == e.last, "out_last", out_last, e.last);
                    if (e.chk_lat)
                        chk(cyc - e.acc_cyc == 3, "latency", cyc - e.acc_cyc, 3);
                    if (e.last) begin
                        exp_done = 1;
                        handoff_now = 1;
                    end
                end
            end
            chk(done == exp_done, "done", done, exp_done);
            prev_stall = out_valid && !out_ready;
            held_p = out_point;
            held_d = out_dist;
            held_l = out_last;
        end
    end

    // Random backpressure when enabled
    always begin
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [63:0] p);
        bit acc;
        int t;
        in_point = p;
        in_valid = 1'b1;
        acc = 0;
        t = 0;
        while (!acc && t < 2000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) chk(0, "send_timeout", t, 0);
    endtask

    task automatic load_query(input logic [63:0] q);
        q_point = q;
        q_load = 1'b1;
        @(posedge clk);
        #1;
        q_load = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        int t;
        seen = 0;
        t = 0;
        while (!seen && t < 5000) begin
            @(negedge clk);
            seen = done;
            if (!seen) begin
                @(posedge clk);
                #1;
            end
            t++;
        end
        if (!seen) chk(0, "done_timeout", t, 0);
    endtask

    task automatic check_reset_outputs();
        chk(in_ready == 0 && out_valid == 0 && out_last == 0 && busy == 0 && done == 0,
            "reset_ctrl", {in_ready, out_valid, out_last, busy, done}, 0);
        chk(out_point == 0, "reset_point", out_point, 0);
        chk(out_dist == 0, "reset_dist", out_dist, 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        m_idle = 1;
        m_cnt = 0;
        handoff_now = 0;
        prev_stall = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        q_load = 1'b0;
        q_point = '0;
        in_valid = 1'b0;
        in_point = '0;
        out_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Query (0,0): lone point for latency, backpressured ramp, random tail
        load_query(pt(0, 0));
        lat_mode = 1;
        send(pt(3, 4));
        in_valid = 1'b0;
        lat_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        fork
            begin
                for (int k = 1; k <= 10; k++) send(pt(k, 0));
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        rnd_ready = 1;
        for (int i = 0; i < 53; i++) begin
            if (i == 10) begin
                q_load = 1'b1;
                q_point = pt(100, 100);
            end
            send(rnd_point());
            q_load = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        // Keep offering a 65th point: it must not be taken
        in_point = pt(7, 7);
        in_valid = 1'b1;
        wait_done();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rnd_ready = 0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Signed extremes, with q_load held across the final handoff
        load_query(pt(32'h8000_0000, 32'h8000_0000));
        send(pt(32'h7FFF_FFFF, 32'h7FFF_FFFF));
        rnd_ready = 1;
        for (int i = 0; i < 63; i++) send(rnd_point());
        in_valid = 1'b0;
        q_point = pt(5, 5);
        q_load = 1'b1;
        wait_done();
        @(posedge clk);
        #1;
        q_load = 1'b0;
        rnd_ready = 0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Swapped extremes
        load_query(pt(32'h7FFF_FFFF, 32'h7FFF_FFFF));
        send(pt(32'h8000_0000, 32'h8000_0000));
        rnd_ready = 1;
        for (int i = 0; i < 63; i++) send(rnd_point());
        in_valid = 1'b0;
        wait_done();
        @(posedge clk);
        #1;
        rnd_ready = 0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset with results in flight, then a clean restart
        load_query(pt(0, 0));
        for (int i = 0; i < 20; i++) send(rnd_point());
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        load_query(pt(0, 0));
        lat_mode = 1;
        send(pt(3, 4));
        in_valid = 1'b0;
        lat_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        rnd_ready = 1;
        for (int i = 0; i < 63; i++) send(rnd_point());
        in_valid = 1'b0;
        wait_done();
        @(posedge clk);
        #1;
        rnd_ready = 0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk(sb.size() == 0, "scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/k_nns_dist_pipe.md
Name: k_nns_dist_pipe

Overview:
- Streaming front-end directly upstream of the sequential k-NN sorter.
- For one query point, accepts a stream of N database points (x,y) over a valid/ready handshake.
- Computes the exact squared Euclidean distance of each point to the query in a 3-stage stall-able pipeline.
- Emits {point, distance, last} to the sorter, with end-of-query signalling.

Parameters:
- W, 32, signed coordinate width. Each point is {x[2W-1:W], y[W-1:0]}, two's complement.
- N, 64, number of database points per query; must be ≥ 1.
- CW, 7, point-counter width; must satisfy 2^CW ≥ N+1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- q_load  in  1  load query; honoured only in IDLE.
- q_point  in  2W  query point {x,y}; sampled when q_load is honoured.
- in_valid  in  1  database point valid.
- in_ready  out  1  block accepts in_point this cycle.
- in_point  in  2W  database point {x,y}.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_point  out  2W  database point, passed through unchanged.
- out_dist  out  2W+1  squared distance, unsigned.
- out_last  out  1  marks the result of the Nth point.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when the last result is accepted.

Behaviour:
- Reset (rst=0, async): state=IDLE, query=0, count=0, all stage valid bits=0. Outputs during reset: in_ready=0, out_valid=0, out_last=0, busy=0, done=0, out_point=0, out_dist=0.
- FSM states:
  - IDLE: in_ready=0. q_load=1 latches q_point and clears count; next state RUN.
  - RUN: in_ready=en. Accept occurs when in_valid & in_ready; each accept increments count. The accept that takes count to N moves the FSM to DRAIN in the same edge.
  - DRAIN: in_ready=0. When out_valid & out_ready & out_last, assert done for one cycle; next state IDLE.
- q_load outside IDLE is ignored; the query register stays unchanged.
- Stall rule: en = !v3 | out_ready. One global enable covers all three stages; all stages advance together or hold together. No bubble collapse is required.
- Pipeline stages (registered data, each with a valid bit):
  - S1: dx = sx(x) − sx(qx), dy = sx(y) − sx(qy), both W+1 bits signed. Carries the point and a last flag.
  - S2: sqx = dx·dx, sqy = dy·dy, each 2W bits unsigned. |d| ≤ 2^W−1, so no overflow.
  - S3: dist = sqx + sqy, 2W+1 bits, exact with no truncation.
- Latency: a point accepted at edge t appears on the outputs after edge t+2, i.e. out_valid is high in cycle t+3, provided there are no stalls.
- Throughput: one point per cycle while out_ready=1.
- out_valid = v3. While out_valid=1 and out_ready=0, out_point, out_dist and out_last hold stable.
- out_last is set on the S1 entry whose accept brings count to N; it travels with its data.
- Ordering: results leave in the same order points were accepted. No loss or duplication under any out_ready pattern.
- With in_valid=0 in RUN, bubbles propagate and count is unchanged.
- Reset asserted mid-stream: all in-flight results are discarded and the block returns to IDLE. The next query starts cleanly.
- Simultaneous out_last handoff and q_load in the same cycle: done pulses, and q_load is ignored because the state is not yet IDLE.

Test Plan:
- Basic latency: load query (0,0); send one point (3,4) with out_ready=1. Required: out_valid in the 3rd cycle after accept, out_dist=25, out_point=(3,4).
- Signed extremes: query (−2^31,−2^31), point (2^31−1, 2^31−1). Required: out_dist=0x1_FFFF_FFFC_0000_0002. Then swap query and point; the distance must be identical.
- Backpressure: in_valid held high with points 1..10 at (k,0) against query (0,0); out_ready low for cycles 4–8. Required: in_ready drops while S3 is stalled, no point is lost or repeated, and distances arrive in order 1,4,9,…,100.
- Query boundary with N=64: stream 64 points, then hold in_valid=1. Required: out_last only on the 64th result, in_ready=0 after the 64th accept, done pulses once, and a 65th point is accepted only after a new q_load.
- q_load while busy: pulse q_load with q_point=(100,100) mid-stream. Required: later distances still use the original query, and busy stays high.
- Reset mid-operation: deassert rst for one cycle after 20 points with 3 in flight. Required: outputs go to 0 immediately; after reset releases, a fresh query with the point (3,4) again yields out_dist=25 with correct latency and no stale result.
